// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the CPU memory subsystem.
//   CPU_DATA_W : CPU data bus width
//   CPU_ADDR_W : CPU address bus width
//   CPU_DEPTH  : words in the program/data RAM (2**CPU_ADDR_W)
//   loader_state_e : boot loader phases ZERO -> LOAD -> RUN
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 8;
  localparam int unsigned CPU_ADDR_W = 4;
  localparam int unsigned CPU_DEPTH  = 16;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } loader_state_e;

endpackage

// File: rtl/ram_16x8.sv
// Word-addressed RAM with combinational read and one synchronous write port.
//   clk   : rising-edge clock
//   we    : write enable, sampled at posedge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational; reflects the old word until the write edge
module ram_16x8
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DEPTH  = CPU_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader_ram.sv
// Program/data RAM with a boot loader in front of it.
// After reset the array is zero-filled, then a program byte stream is written
// from address 0 upward while the CPU is held in clear. The CPU is then
// released and served by an async-read / sync-write memory port.
//   clk          : rising-edge clock
//   clr          : synchronous reset, active-low
//   load_valid   : loader beat valid
//   load_data    : loader byte
//   load_last    : final beat of the program
//   load_ready   : loader may present a beat
//   reload       : 1-cycle pulse, restarts the boot sequence (RUN only)
//   cpu_clr      : CPU clear; 1 holds the CPU in clear
//   trunc        : sticky, the array filled up without load_last
//   cpu_read     : CPU read strobe (reads are combinational, unused here)
//   cpu_write    : CPU write strobe
//   cpu_address  : CPU address
//   cpu_data_in  : CPU write data
//   cpu_data_out : CPU read data, 0 outside RUN
module program_loader_ram
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DEPTH  = CPU_DEPTH
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              cpu_clr,
  output logic              trunc,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_in,
  output logic [DATA_W-1:0] cpu_data_out
);

  localparam int unsigned      PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  loader_state_e     state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              trunc_q, trunc_d;
  logic              cpu_clr_q, cpu_clr_d;
  logic              load_ready_q, load_ready_d;

  logic              beat_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Reads are combinational; the strobe carries no information for the array.
  logic unused_cpu_read;
  assign unused_cpu_read = cpu_read;

  assign beat_accept = load_valid & load_ready_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    trunc_d      = trunc_q;
    cpu_clr_d    = cpu_clr_q;
    load_ready_d = load_ready_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q[ADDR_W-1:0];
    mem_wdata    = '0;

    unique case (state_q)
      ZERO: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) begin
          ptr_d        = '0;
          state_d      = LOAD;
          load_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (beat_accept) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          ptr_d     = ptr_q + PTR_ONE;
          if (load_last || (ptr_q == PTR_LAST)) begin
            state_d      = RUN;
            load_ready_d = 1'b0;
          end
          if ((ptr_q == PTR_LAST) && !load_last) begin
            trunc_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Clear drops one cycle after entry so the CPU sees one clear edge
        // after the load completes.
        cpu_clr_d = 1'b0;
        if (cpu_write) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_address;
          mem_wdata = cpu_data_in;
        end
        // A CPU write in the reload cycle still commits above.
        if (reload) begin
          cpu_clr_d = 1'b1;
          ptr_d     = '0;
          trunc_d   = 1'b0;
          state_d   = ZERO;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= ZERO;
      ptr_q        <= '0;
      trunc_q      <= 1'b0;
      cpu_clr_q    <= 1'b1;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      trunc_q      <= trunc_d;
      cpu_clr_q    <= cpu_clr_d;
      load_ready_q <= load_ready_d;
    end
  end

  // The array is left untouched in the reset cycle; ZERO clears it.
  ram_16x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we & clr),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (cpu_address),
    .rdata (mem_rdata)
  );

  assign load_ready   = load_ready_q;
  assign cpu_clr      = cpu_clr_q;
  assign trunc        = trunc_q;
  assign cpu_data_out = (state_q == RUN) ? mem_rdata : '0;

endmodule

// File: tb/tb_program_loader_ram.sv
module tb_program_loader_ram;

  logic       clk;
  logic       clr;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       reload;
  logic       cpu_clr;
  logic       trunc;
  logic       cpu_read;
  logic       cpu_write;
  logic [3:0] cpu_address;
  logic [7:0] cpu_data_in;
  logic [7:0] cpu_data_out;

  int unsigned n_assert;
  int unsigned n_fail;

  logic [7:0] exp_mem [16];
  int unsigned load_ptr;
  logic [7:0] sb_q [$];

  program_loader_ram dut (
    .clk          (clk),
    .clr          (clr),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .reload       (reload),
    .cpu_clr      (cpu_clr),
    .trunc        (trunc),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    load_ptr = 0;
  endtask

  task automatic send_beat(input logic [7:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    exp_mem[load_ptr] = data;
    load_ptr++;
  endtask

  // Bounded wait for the loader to open after zero-fill.
  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (load_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 8'(load_ready), 8'd1);
  endtask

  // Scoreboard readback through the CPU port (RUN only).
  task automatic readback(input string tag);
    logic [7:0] exp;
    for (int a = 0; a < 16; a++) sb_q.push_back(exp_mem[a]);
    for (int a = 0; a < 16; a++) begin
      cpu_address = 4'(a);
      #1;
      exp = sb_q.pop_front();
      check($sformatf("%s[%0d]", tag, a), cpu_data_out, exp);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    clr         = 1'b0;
    load_valid  = 1'b0;
    load_data   = 8'h00;
    load_last   = 1'b0;
    reload      = 1'b0;
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    cpu_address = 4'h0;
    cpu_data_in = 8'h00;
    model_zero();

    // 1. reset state, zero-fill timing
    tick();
    check("rst_load_ready", 8'(load_ready), 8'd0);
    check("rst_cpu_clr",    8'(cpu_clr),    8'd1);
    check("rst_trunc",      8'(trunc),      8'd0);
    check("rst_data_out",   cpu_data_out,   8'h00);
    clr = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("zero_ready_c%0d", i), 8'(load_ready), 8'd0);
    end
    tick();
    check("ready_rise", 8'(load_ready), 8'd1);

    // 4b. CPU write during LOAD is ignored; data_out is 0 outside RUN
    cpu_write   = 1'b1;
    cpu_address = 4'h5;
    cpu_data_in = 8'hEE;
    tick();
    cpu_write = 1'b0;
    check("load_data_out_zero", cpu_data_out, 8'h00);

    // 2. four-beat program
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    check("p4_ready_drop", 8'(load_ready), 8'd0);
    check("p4_cpu_clr_hold", 8'(cpu_clr), 8'd1);
    tick();
    check("p4_cpu_clr_fall", 8'(cpu_clr), 8'd0);
    check("p4_trunc", 8'(trunc), 8'd0);
    readback("p4_mem");

    // 4. RUN write/read, read-during-write sees old word
    cpu_write   = 1'b1;
    cpu_address = 4'hF;
    cpu_data_in = 8'hA5;
    #1;
    check("rdw_old", cpu_data_out, 8'h00);
    tick();
    cpu_write = 1'b0;
    check("run_write_F", cpu_data_out, 8'hA5);
    exp_mem[15] = 8'hA5;
    readback("run_mem");

    // 6. reload pulse: restart, rezero, new program
    pulse_reload();
    check("rl_cpu_clr", 8'(cpu_clr), 8'd1);
    check("rl_data_out", cpu_data_out, 8'h00);
    check("rl_ready", 8'(load_ready), 8'd0);
    model_zero();
    wait_ready("rl_wait_ready");
    send_beat(8'h5A, 1'b0);
    send_beat(8'hC3, 1'b0);
    send_beat(8'h0F, 1'b1);
    tick();
    check("rl_cpu_clr_fall", 8'(cpu_clr), 8'd0);
    readback("rl_mem");

    // 3. truncated sixteen-beat program
    pulse_reload();
    model_zero();
    wait_ready("tr_wait_ready");
    for (int i = 0; i < 15; i++) send_beat(8'(8'h80 + i), 1'b0);
    check("tr_trunc_pre", 8'(trunc), 8'd0);
    check("tr_ready_pre", 8'(load_ready), 8'd1);
    send_beat(8'h8F, 1'b0);
    check("tr_trunc", 8'(trunc), 8'd1);
    check("tr_ready_drop", 8'(load_ready), 8'd0);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    tick();
    load_valid = 1'b0;
    check("tr_cpu_clr_fall", 8'(cpu_clr), 8'd0);
    check("tr_trunc_sticky", 8'(trunc), 8'd1);
    readback("tr_mem");

    // 5. reset mid-load, plus reload outside RUN is ignored
    pulse_reload();
    check("r5_trunc_cleared", 8'(trunc), 8'd0);
    model_zero();
    wait_ready("r5_wait_ready");
    pulse_reload();
    check("r5_reload_ignored", 8'(load_ready), 8'd1);
    send_beat(8'h11, 1'b0);
    load_valid = 1'b1;
    load_data  = 8'h22;
    clr        = 1'b0;
    tick();
    load_valid = 1'b0;
    clr        = 1'b1;
    check("r5_ready", 8'(load_ready), 8'd0);
    check("r5_cpu_clr", 8'(cpu_clr), 8'd1);
    check("r5_data_out", cpu_data_out, 8'h00);
    model_zero();
    for (int i = 0; i < 15; i++) tick();
    check("r5_still_zero", 8'(load_ready), 8'd0);
    tick();
    check("r5_ready_rise", 8'(load_ready), 8'd1);
    send_beat(8'h99, 1'b1);
    tick();
    check("r5_cpu_clr_fall", 8'(cpu_clr), 8'd0);
    readback("r5_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
